// File: rtl/sa_autosa_glb_intr_sched.sv
// Round-robin service sequencer for the GLB done-status bank: offers one pending
// unmasked source, issues its write-1-to-clear and waits (bounded) for the bit to fall.
module sa_autosa_glb_intr_sched #(
    parameter int NUM_SRC = 12,
    parameter int ID_W    = 4,
    parameter int TMO_W   = 8,
    parameter int CNT_W   = 16
) (
    input  logic               autosa_core_clk,
    input  logic               autosa_core_rst,
    input  logic               enable,
    input  logic [NUM_SRC-1:0] src_status,
    input  logic [NUM_SRC-1:0] src_mask,
    output logic               evt_valid,
    output logic [ID_W-1:0]    evt_id,
    input  logic               evt_ready,
    output logic               clr_valid,
    output logic [NUM_SRC-1:0] clr_vec,
    input  logic               clr_ready,
    input  logic [TMO_W-1:0]   tmo_limit,
    output logic               busy,
    output logic               err,
    output logic [ID_W-1:0]    err_id,
    input  logic               err_clr,
    output logic [CNT_W-1:0]   svc_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESENT   = 2'd1,
        ST_CLEAR     = 2'd2,
        ST_WAIT_DROP = 2'd3
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [ID_W-1:0]    cur_id_r, cur_id_nxt_s, cur_id_inc_s;
    logic [ID_W-1:0]    rr_ptr_r, rr_ptr_nxt_s;
    logic [ID_W-1:0]    pick_id_s, scan_id_s;
    logic               pick_found_s;
    int                 scan_idx_s;
    logic [NUM_SRC-1:0] pending_s;
    logic [TMO_W-1:0]   tmo_cnt_r, tmo_cnt_nxt_s;
    logic [CNT_W-1:0]   svc_cnt_r, svc_cnt_nxt_s;
    logic               err_r, err_nxt_s, tmo_hit_s;
    logic [ID_W-1:0]    err_id_r, err_id_nxt_s;
    logic               evt_valid_r, clr_valid_r, busy_r;
    logic [NUM_SRC-1:0] clr_vec_r;

    function automatic logic [NUM_SRC-1:0] id_onehot(input logic [ID_W-1:0] id);
        logic [NUM_SRC-1:0] vec;
        for (int i = 0; i < NUM_SRC; i++) begin
            vec[i] = (id == ID_W'(i));
        end
        return vec;
    endfunction

    assign pending_s    = src_status & ~src_mask;
    assign cur_id_inc_s = (cur_id_r == ID_W'(NUM_SRC - 1)) ? {ID_W{1'b0}} : cur_id_r + ID_W'(1);

    // First pending source at or after rr_ptr_r, wrapping past the last source
    always_comb begin
        pick_id_s    = {ID_W{1'b0}};
        pick_found_s = 1'b0;
        scan_idx_s   = 0;
        scan_id_s    = {ID_W{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            scan_idx_s = int'(rr_ptr_r) + i;
            if (scan_idx_s >= NUM_SRC) begin
                scan_idx_s = scan_idx_s - NUM_SRC;
            end else begin
                scan_idx_s = scan_idx_s;
            end
            scan_id_s = ID_W'(scan_idx_s);
            if (!pick_found_s && pending_s[scan_id_s]) begin
                pick_id_s    = scan_id_s;
                pick_found_s = 1'b1;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Service sequencing: next state, timeout counting and bookkeeping
    always_comb begin
        state_nxt_s   = state_r;
        cur_id_nxt_s  = cur_id_r;
        rr_ptr_nxt_s  = rr_ptr_r;
        tmo_cnt_nxt_s = tmo_cnt_r;
        svc_cnt_nxt_s = svc_cnt_r;
        err_id_nxt_s  = err_id_r;
        tmo_hit_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable && pick_found_s) begin
                    state_nxt_s  = ST_PRESENT;
                    cur_id_nxt_s = pick_id_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PRESENT: begin
                if (evt_ready) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_PRESENT;
                end
            end
            ST_CLEAR: begin
                if (clr_ready) begin
                    state_nxt_s   = ST_WAIT_DROP;
                    tmo_cnt_nxt_s = {TMO_W{1'b0}};
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_WAIT_DROP: begin
                // a falling bit wins over a timeout landing in the same cycle
                if (!src_status[cur_id_r]) begin
                    state_nxt_s  = ST_IDLE;
                    rr_ptr_nxt_s = cur_id_inc_s;
                    if (svc_cnt_r != {CNT_W{1'b1}}) begin
                        svc_cnt_nxt_s = svc_cnt_r + CNT_W'(1);
                    end else begin
                        svc_cnt_nxt_s = svc_cnt_r;
                    end
                end else if (tmo_cnt_r == tmo_limit) begin
                    state_nxt_s  = ST_IDLE;
                    rr_ptr_nxt_s = cur_id_inc_s;
                    err_id_nxt_s = cur_id_r;
                    tmo_hit_s    = 1'b1;
                end else begin
                    tmo_cnt_nxt_s = tmo_cnt_r + TMO_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        if (tmo_hit_s) begin
            err_nxt_s = 1'b1;
        end else if (err_clr) begin
            err_nxt_s = 1'b0;
        end else begin
            err_nxt_s = err_r;
        end
    end

    // State and registered outputs, all derived from the next state
    always_ff @(posedge autosa_core_clk) begin
        if (autosa_core_rst) begin
            state_r     <= ST_IDLE;
            cur_id_r    <= {ID_W{1'b0}};
            rr_ptr_r    <= {ID_W{1'b0}};
            tmo_cnt_r   <= {TMO_W{1'b0}};
            svc_cnt_r   <= {CNT_W{1'b0}};
            err_r       <= 1'b0;
            err_id_r    <= {ID_W{1'b0}};
            evt_valid_r <= 1'b0;
            clr_valid_r <= 1'b0;
            clr_vec_r   <= {NUM_SRC{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cur_id_r    <= cur_id_nxt_s;
            rr_ptr_r    <= rr_ptr_nxt_s;
            tmo_cnt_r   <= tmo_cnt_nxt_s;
            svc_cnt_r   <= svc_cnt_nxt_s;
            err_r       <= err_nxt_s;
            err_id_r    <= err_id_nxt_s;
            evt_valid_r <= (state_nxt_s == ST_PRESENT);
            clr_valid_r <= (state_nxt_s == ST_CLEAR);
            clr_vec_r   <= (state_nxt_s == ST_CLEAR) ? id_onehot(cur_id_nxt_s) : {NUM_SRC{1'b0}};
            busy_r      <= (state_nxt_s != ST_IDLE);
        end
    end

    assign evt_valid = evt_valid_r;
    assign evt_id    = cur_id_r;
    assign clr_valid = clr_valid_r;
    assign clr_vec   = clr_vec_r;
    assign busy      = busy_r;
    assign err       = err_r;
    assign err_id    = err_id_r;
    assign svc_cnt   = svc_cnt_r;

endmodule

// File: tb/tb_sa_autosa_glb_intr_sched.sv
// Randomized scoreboard bench for sa_autosa_glb_intr_sched: a transaction-level model predicts
// pick order, clear vectors and service/timeout outcomes; a negedge monitor checks the handshakes.
module tb_sa_autosa_glb_intr_sched;
    localparam int NUM_SRC = 12;
    localparam int ID_W    = 4;
    localparam int TMO_W   = 8;
    localparam int CNT_W   = 4;   // small so saturation is reachable
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               autosa_core_clk = 1'b0;
    logic               autosa_core_rst = 1'b1;
    logic               enable = 1'b0;
    logic [NUM_SRC-1:0] src_status = '0;
    logic [NUM_SRC-1:0] src_mask = '0;
    logic               evt_valid;
    logic [ID_W-1:0]    evt_id;
    logic               evt_ready = 1'b0;
    logic               clr_valid;
    logic [NUM_SRC-1:0] clr_vec;
    logic               clr_ready = 1'b0;
    logic [TMO_W-1:0]   tmo_limit = '0;
    logic               busy;
    logic               err;
    logic [ID_W-1:0]    err_id;
    logic               err_clr = 1'b0;
    logic [CNT_W-1:0]   svc_cnt;

    sa_autosa_glb_intr_sched #(.NUM_SRC(NUM_SRC), .ID_W(ID_W), .TMO_W(TMO_W), .CNT_W(CNT_W)) dut (
        .autosa_core_clk(autosa_core_clk), .autosa_core_rst(autosa_core_rst), .enable(enable),
        .src_status(src_status), .src_mask(src_mask), .evt_valid(evt_valid), .evt_id(evt_id),
        .evt_ready(evt_ready), .clr_valid(clr_valid), .clr_vec(clr_vec), .clr_ready(clr_ready),
        .tmo_limit(tmo_limit), .busy(busy), .err(err), .err_id(err_id), .err_clr(err_clr),
        .svc_cnt(svc_cnt)
    );

    always #5 autosa_core_clk = ~autosa_core_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int                 exp_evt_q[$];
    logic [NUM_SRC-1:0] exp_clr_q[$];

    // reference model state
    int m_rr = 0, m_svc = 0, m_err = 0, m_err_id = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    task automatic step();
        @(posedge autosa_core_clk);
        #2;
    endtask

    function automatic int model_pick(input logic [NUM_SRC-1:0] p, input int rr);
        for (int i = 0; i < NUM_SRC; i++) begin
            if (p[(rr + i) % NUM_SRC]) return (rr + i) % NUM_SRC;
        end
        return -1;
    endfunction

    // Monitor: pops expectations on handshakes and checks hold/latency rules
    logic               prev_evt_hs = 1'b0, prev_clr_hs = 1'b0, prev_evt_wait = 1'b0, prev_clr_wait = 1'b0;
    logic [ID_W-1:0]    prev_id = '0;
    logic [NUM_SRC-1:0] prev_vec = '0;
    always @(negedge autosa_core_clk) begin
        if (autosa_core_rst) begin
            prev_evt_hs = 1'b0; prev_clr_hs = 1'b0; prev_evt_wait = 1'b0; prev_clr_wait = 1'b0;
        end else begin
            check("evt_id_range", 32'(evt_id < ID_W'(NUM_SRC)), 32'd1);
            if (prev_evt_hs) begin
                check("evt_valid_after_hs", 32'(evt_valid), 32'd0);
                check("clr_valid_after_evt_hs", 32'(clr_valid), 32'd1);
            end
            if (prev_clr_hs) check("clr_valid_after_hs", 32'(clr_valid), 32'd0);
            if (prev_evt_wait) begin
                check("evt_valid_hold", 32'(evt_valid), 32'd1);
                check("evt_id_hold", 32'(evt_id), 32'(prev_id));
            end
            if (prev_clr_wait) begin
                check("clr_valid_hold", 32'(clr_valid), 32'd1);
                check("clr_vec_hold", 32'(clr_vec), 32'(prev_vec));
            end
            if (evt_valid && evt_ready) begin
                if (exp_evt_q.size() == 0) check("evt_unexpected", 32'(evt_id), 32'hFFFF_FFFF);
                else check("evt_id", 32'(evt_id), 32'(exp_evt_q.pop_front()));
            end
            if (clr_valid && clr_ready) begin
                if (exp_clr_q.size() == 0) check("clr_unexpected", 32'(clr_vec), 32'hFFFF_FFFF);
                else check("clr_vec", 32'(clr_vec), 32'(exp_clr_q.pop_front()));
            end
            prev_evt_hs   = evt_valid && evt_ready;
            prev_clr_hs   = clr_valid && clr_ready;
            prev_evt_wait = evt_valid && !evt_ready;
            prev_clr_wait = clr_valid && !clr_ready;
            prev_id       = evt_id;
            prev_vec      = clr_vec;
        end
    end

    task automatic check_outcome(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_svc_cnt"}, 32'(svc_cnt), 32'(m_svc));
        check({tag, "_err"}, 32'(err), 32'(m_err));
        check({tag, "_err_id"}, 32'(err_id), 32'(m_err_id));
    endtask

    // One service: d = WAIT_DROP cycle at which the bit falls; ec = err_clr at the final edge (2 = random)
    task automatic run_txn(input logic [NUM_SRC-1:0] st, input logic [NUM_SRC-1:0] mk,
                           input int d, input bit bp, input int ec);
        logic [NUM_SRC-1:0] pend, oh;
        int id, budget, tmo;
        bit hs, fin, ecb;
        tmo = int'(tmo_limit);
        src_status = st;
        src_mask   = mk;
        pend       = st & ~mk;
        if (pend == '0) begin
            enable = 1'b1;
            repeat (3) begin
                step();
                check("no_pick_when_idle_pending0", 32'(evt_valid), 32'd0);
            end
            enable = 1'b0;
            return;
        end
        id = model_pick(pend, m_rr);
        oh = '0;
        oh[id] = 1'b1;
        exp_evt_q.push_back(id);
        exp_clr_q.push_back(oh);
        enable    = 1'b1;
        evt_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        clr_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        step();
        check("evt_valid_latency", 32'(evt_valid), 32'd1);
        check("busy_in_service", 32'(busy), 32'd1);
        enable = 1'b0;
        budget = 0;
        forever begin
            evt_ready = bp ? 1'($urandom_range(0, 2) != 0) : 1'b1;
            clr_ready = bp ? 1'($urandom_range(0, 2) != 0) : 1'b1;
            if (bp) begin
                src_status = NUM_SRC'($urandom);
                src_mask   = NUM_SRC'($urandom);
            end
            hs = clr_valid && clr_ready;
            step();
            if (hs) break;
            budget++;
            if (budget > 200) begin
                check("clear_handshake_timeout", 32'(budget), 32'd0);
                finish_run();
            end
        end
        for (int j = 0; ; j++) begin
            src_status     = st;
            src_status[id] = (j < d);
            fin = (j >= d) || (j == tmo);
            ecb = (ec == 2) ? 1'($urandom_range(0, 1)) : (ec != 0);
            err_clr = fin ? ecb : 1'b0;
            if (!fin) check("busy_wait_drop", 32'(busy), 32'd1);
            step();
            if (fin) break;
        end
        err_clr = 1'b0;
        if (d <= tmo) begin
            m_svc = (m_svc < CNT_MAX) ? m_svc + 1 : CNT_MAX;
            if (ecb) m_err = 0;
        end else begin
            m_err    = 1;
            m_err_id = id;
        end
        m_rr = (id + 1) % NUM_SRC;
        src_status[id] = 1'b0;
        check_outcome("txn");
    endtask

    initial begin
        #200000;
        check("global_watchdog", 32'd1, 32'd0);
        finish_run();
    end

    initial begin
        logic [NUM_SRC-1:0] st, mk;
        int d, tl;
        step();
        step();
        check("rst_evt_valid", 32'(evt_valid), 32'd0);
        check("rst_evt_id", 32'(evt_id), 32'd0);
        check("rst_clr_valid", 32'(clr_valid), 32'd0);
        check("rst_clr_vec", 32'(clr_vec), 32'd0);
        check_outcome("rst");
        autosa_core_rst = 1'b0;

        // single source, zero-wait handshakes, bit falls on the first WAIT_DROP cycle
        tmo_limit = 8'd5;
        run_txn(12'h004, 12'h000, 0, 1'b0, 0);

        // reset while an event is being presented
        src_status = 12'h003; enable = 1'b1; evt_ready = 1'b0;
        step();
        check("pre_rst_evt_valid", 32'(evt_valid), 32'd1);
        enable = 1'b0;
        step();
        autosa_core_rst = 1'b1;
        step();
        check("midrst_evt_valid", 32'(evt_valid), 32'd0);
        check("midrst_evt_id", 32'(evt_id), 32'd0);
        check("midrst_clr_valid", 32'(clr_valid), 32'd0);
        check("midrst_clr_vec", 32'(clr_vec), 32'd0);
        m_rr = 0; m_svc = 0; m_err = 0; m_err_id = 0;
        check_outcome("midrst");
        autosa_core_rst = 1'b0;
        src_status = '0;

        // round robin over 0x811, then with bit 4 masked
        repeat (4) run_txn(12'h811, 12'h000, 1, 1'b0, 0);
        repeat (2) run_txn(12'h811, 12'h010, 0, 1'b0, 0);

        // backpressure with status/mask churn during PRESENT and CLEAR
        repeat (3) run_txn(12'h0A0, 12'h000, 2, 1'b1, 0);

        // timeouts: limit 3 on bit 6, then a second timeout with err_clr in the same cycle
        tmo_limit = 8'd3;
        run_txn(12'h040, 12'h000, 99, 1'b0, 0);
        run_txn(12'h040, 12'h000, 99, 1'b0, 1);
        tmo_limit = 8'd0;
        run_txn(12'h200, 12'h000, 99, 1'b0, 0);
        tmo_limit = 8'd2;
        run_txn(12'h002, 12'h000, 2, 1'b0, 1);

        // enable low blocks picks while pending
        src_status = 12'h00F; enable = 1'b0;
        repeat (3) begin
            step();
            check("enable_low_no_evt", 32'(evt_valid), 32'd0);
        end

        for (int k = 0; k < 70; k++) begin
            tl = $urandom_range(0, 4);
            tmo_limit = TMO_W'(tl);
            st = NUM_SRC'($urandom);
            mk = NUM_SRC'($urandom) & NUM_SRC'($urandom);
            if (k % 9 == 0) mk = st;
            d = ($urandom_range(0, 3) == 0) ? 99 : $urandom_range(0, tl + 1);
            run_txn(st, mk, d, 1'b1, 2);
        end

        step();
        check("evt_queue_drained", 32'(exp_evt_q.size()), 32'd0);
        check("clr_queue_drained", 32'(exp_clr_q.size()), 32'd0);
        finish_run();
    end

endmodule

// File: doc/sa_autosa_glb_intr_sched.md
Name: sa_autosa_glb_intr_sched

Overview:
Interrupt service sequencer for the GLB done-status bank.
- Watches the per-source done-status vector and its mask.
- Picks one pending, unmasked source by round-robin and hands its ID to the service agent over a valid/ready event port.
- Issues the write-1-to-clear request for that source and waits until the status bit falls.
- Flags a sticky error if the bit does not fall within a programmable timeout.
- Sits between the GLB interrupt-status registers and the falcon-side handler logic, in the core clock domain.

Parameters:
NUM_SRC, 12, number of done-status sources (bit order: sdp0, sdp1, cdp0, cdp1, pdp0, pdp1, cdma_dat0, cdma_dat1, cdma_wt0, cdma_wt1, cacc0, cacc1)
ID_W, 4, width of source index; 2^ID_W >= NUM_SRC
TMO_W, 8, width of clear-timeout counter and limit
CNT_W, 16, width of serviced-event counter

Ports:
autosa_core_clk  in  1  core clock; the only clock
autosa_core_rst  in  1  synchronous, active-high reset
enable  in  1  1 = new picks allowed
src_status  in  NUM_SRC  done-status vector
src_mask  in  NUM_SRC  1 = source masked
evt_valid  out  1  event offered to service agent
evt_id  out  ID_W  index of offered source
evt_ready  in  1  service agent accepts event
clr_valid  out  1  clear request valid
clr_vec  out  NUM_SRC  one-hot write-1-to-clear data
clr_ready  in  1  clear request accepted
tmo_limit  in  TMO_W  max WAIT_DROP cycles before error
busy  out  1  state != IDLE
err  out  1  sticky clear-timeout flag
err_id  out  ID_W  source that timed out (last)
err_clr  in  1  clears err
svc_cnt  out  CNT_W  serviced events, saturating

Behaviour:
- Reset (sync, autosa_core_rst=1 at clock edge): state=IDLE, rr_ptr=0, all outputs 0 (evt_valid, evt_id, clr_valid, clr_vec, busy, err, err_id, svc_cnt). Reset mid-operation abandons any handshake immediately; no clear is issued.
- pending = src_status & ~src_mask. It is evaluated combinationally only in IDLE.
- IDLE: if enable and pending != 0, select the first set bit scanning rr_ptr, rr_ptr+1, … wrapping at NUM_SRC-1 -> 0. Register it as cur_id and go to PRESENT. evt_valid rises the cycle after pending was seen.
- PRESENT: evt_valid=1, evt_id=cur_id, both held stable until evt_valid&evt_ready. This holds even if the status bit or mask changes meanwhile. On handshake go to CLEAR; evt_valid=0 next cycle.
- CLEAR: clr_valid=1, clr_vec=1<<cur_id, both held until clr_ready. On handshake go to WAIT_DROP and load tmo_cnt=0.
- WAIT_DROP, checked each cycle:
  - If src_status[cur_id]==0: go to IDLE, svc_cnt+=1 (saturate at all-ones), rr_ptr=cur_id+1 (wrap to 0 after NUM_SRC-1).
  - Else if tmo_cnt==tmo_limit: go to IDLE, err=1, err_id=cur_id, rr_ptr advances as above, svc_cnt unchanged.
  - Else tmo_cnt+=1.
  - Drop has priority over timeout in the same cycle.
  - tmo_limit=0 means a timeout on the first WAIT_DROP cycle if the bit is still high.
- Back-to-back service: the earliest re-pick is the cycle after returning to IDLE. Minimum service is 4 cycles (IDLE, PRESENT, CLEAR, WAIT_DROP) with zero-wait handshakes.
- enable=0 blocks only new picks in IDLE; an in-flight service completes.
- Mask or status changes during PRESENT/CLEAR/WAIT_DROP never abort the service.
- err_clr clears err. If err_clr and a new timeout occur in the same cycle, set wins. err_id is not cleared by err_clr.
- busy = (state != IDLE), registered with the state.
- Bits with index >= NUM_SRC do not exist. evt_id is always < NUM_SRC.

Test Plan:
- Single source: reset, enable=1, mask=0, status=0x004 -> evt_valid one cycle later with evt_id=2. With evt_ready=1 and clr_ready=1, clr_vec=0x004 one cycle after the event handshake. Drop the status bit the cycle after the clear -> svc_cnt=1, busy=0, rr_ptr=3.
- Round-robin: status=0x811 held, each serviced and dropped -> evt_id order 0,4,11, then 0 again after re-setting bit 0; masked bit 4 (mask=0x010) skipped -> order 0,11.
- Backpressure: hold evt_ready=0 for 5 cycles while status[id] clears -> evt_valid and evt_id stay stable; then clr_ready=0 for 3 cycles -> clr_vec stays stable; no ID change.
- Timeout: tmo_limit=3, status bit 6 held high after the clear -> err=1, err_id=6 after 4 WAIT_DROP cycles, svc_cnt unchanged. err_clr asserted together with a second timeout -> err stays 1.
- Boundary: tmo_limit=0 with bit still high -> immediate error. Bit drops on the same cycle tmo_cnt==tmo_limit -> serviced, no error. svc_cnt preset near all-ones saturates.
- Control: enable=0 with pending -> no evt_valid. Deassert enable during CLEAR -> service completes. Assert autosa_core_rst during PRESENT -> next cycle all outputs 0, state IDLE.
